// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw slot sensors and downstream handshake in, coin codes and status out.
interface coin_acceptor_if;
   logic       sense_5;
   logic       sense_10;
   logic       accept_en;
   logic [1:0] coin;
   logic       coin_reject;
   logic       jam;
   logic       pending;

   modport master (
      output sense_5, sense_10, accept_en,
      input  coin, coin_reject, jam, pending
   );

   modport slave (
      input  sense_5, sense_10, accept_en,
      output coin, coin_reject, jam, pending
   );
endinterface

// File: rtl/coin_acceptor.sv
// Two-slot coin acceptor: synchronise and debounce the sensors, classify each insertion,
// and hand validated coins to the vending FSM through a one-entry buffer.
module coin_acceptor #(
   parameter int unsigned DEBOUNCE_CYCLES  = 16,
   parameter int unsigned MAX_PULSE_CYCLES = 200
) (
   input logic            clk,
   input logic            reset,
   coin_acceptor_if.slave bus
);

   localparam int unsigned DW = 8;
   localparam int unsigned WW = 10;
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
   localparam logic [WW-1:0] W_MAX  = WW'(MAX_PULSE_CYCLES);
   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_5    = 2'b01;
   localparam logic [1:0] CODE_10   = 2'b10;

   typedef enum logic [2:0] {IDLE, ACT5, ACT10, BOTH, JAM} state_t;

   logic [1:0]    sync_meta;
   logic [1:0]    sync;
   logic [1:0]    filt;
   logic [DW-1:0] dcnt [2];
   logic [WW-1:0] wcnt;
   state_t        state;
   state_t        state_nxt;
   logic          jam_hit_c;
   logic [1:0]    event_c;
   logic          both_rej_c;
   logic [1:0]    coin_q;
   logic [1:0]    buf_code;
   logic          coin_reject_q;
   logic          jam_q;
   logic          pending_q;
   logic          f5;
   logic          f10;

   assign f5  = filt[0];
   assign f10 = filt[1];

   // Synchroniser plus per-sensor debounce; filter flips once the counter has seen DB_MAX differing cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= '0;
         sync      <= '0;
         filt      <= '0;
         dcnt[0]   <= '0;
         dcnt[1]   <= '0;
      end else begin
         sync_meta <= {bus.sense_10, bus.sense_5};
         sync      <= sync_meta;
         for (int i = 0; i < 2; i++) begin
            if (sync[i] == filt[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DB_MAX) begin
               filt[i] <= sync[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + DW'(1);
            end
         end
      end
   end

   // Active-width counter, held at zero outside the active states and saturating at the jam limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt <= '0;
      end else if (state == IDLE || state == JAM) begin
         wcnt <= '0;
      end else if (wcnt != W_MAX) begin
         wcnt <= wcnt + WW'(1);
      end
   end

   assign jam_hit_c = (wcnt >= W_MAX - WW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state; the jam limit wins over any simultaneous sensor change.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (f5 && f10)  state_nxt = BOTH;
            else if (f5)    state_nxt = ACT5;
            else if (f10)   state_nxt = ACT10;
         end
         ACT5: begin
            if (jam_hit_c)  state_nxt = JAM;
            else if (f10)   state_nxt = BOTH;
            else if (!f5)   state_nxt = IDLE;
         end
         ACT10: begin
            if (jam_hit_c)  state_nxt = JAM;
            else if (f5)    state_nxt = BOTH;
            else if (!f10)  state_nxt = IDLE;
         end
         BOTH: begin
            if (jam_hit_c)       state_nxt = JAM;
            else if (!f5 && !f10) state_nxt = IDLE;
         end
         JAM: begin
            if (!f5 && !f10) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Coin events and the double-coin reject, decoded from the state transition.
   always_comb begin
      event_c    = CODE_NONE;
      both_rej_c = 1'b0;
      if (state_nxt == IDLE) begin
         case (state)
            ACT5:    event_c    = CODE_5;
            ACT10:   event_c    = CODE_10;
            BOTH:    both_rej_c = 1'b1;
            default: event_c    = CODE_NONE;
         endcase
      end
   end

   // One-entry buffer between the classifier and the vending FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coin_q        <= CODE_NONE;
         coin_reject_q <= 1'b0;
         jam_q         <= 1'b0;
         pending_q     <= 1'b0;
         buf_code      <= CODE_NONE;
      end else begin
         coin_q        <= CODE_NONE;
         coin_reject_q <= both_rej_c;
         jam_q         <= (state_nxt == JAM);
         if (bus.accept_en) begin
            if (pending_q) begin
               coin_q <= buf_code;
               if (event_c != CODE_NONE) begin
                  buf_code <= event_c;
               end else begin
                  buf_code  <= CODE_NONE;
                  pending_q <= 1'b0;
               end
            end else begin
               coin_q <= event_c;
            end
         end else if (event_c != CODE_NONE) begin
            if (pending_q) begin
               coin_reject_q <= 1'b1;
            end else begin
               buf_code  <= event_c;
               pending_q <= 1'b1;
            end
         end
      end
   end

   assign bus.coin        = coin_q;
   assign bus.coin_reject = coin_reject_q;
   assign bus.jam         = jam_q;
   assign bus.pending     = pending_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: planned stimulus per scenario, compared cycle by cycle
// against an episode-level reference model of the acceptor.
module tb_coin_acceptor;
   localparam int D      = 4;
   localparam int M      = 50;
   localparam int MAXLEN = 400;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   coin_acceptor_if bus ();

   coin_acceptor #(.DEBOUNCE_CYCLES(D), .MAX_PULSE_CYCLES(M)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Plan: raw sensor / accept_en values sampled at edge t, and observed outputs during cycle t.
   bit         p5   [0:MAXLEN];
   bit         p10  [0:MAXLEN];
   bit         pacc [0:MAXLEN];
   int         plen;
   logic [1:0] o_coin [0:MAXLEN];
   logic       o_rej  [0:MAXLEN];
   logic       o_jam  [0:MAXLEN];
   logic       o_pend [0:MAXLEN];
   bit   [1:0] x_coin [0:MAXLEN+2];
   bit         x_rej  [0:MAXLEN+2];
   bit         x_jam  [0:MAXLEN+2];
   bit         x_pend [0:MAXLEN+2];
   bit   [1:0] ev     [0:MAXLEN+2];
   bit         rev    [0:MAXLEN+2];
   bit         ff5    [0:MAXLEN];
   bit         ff10   [0:MAXLEN];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic clear_plan();
      for (int t = 0; t <= MAXLEN; t++) begin
         p5[t] = 1'b0; p10[t] = 1'b0; pacc[t] = 1'b0;
      end
      plen = 0;
   endtask

   task automatic add_pulse(input bit sel10, input int start, input int width);
      for (int t = start; t < start + width; t++) begin
         if (sel10) p10[t] = 1'b1;
         else       p5[t]  = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.sense_5 = p5[0]; bus.sense_10 = p10[0]; bus.accept_en = pacc[0];
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_plan();
      do_reset();
      for (int t = 1; t <= plen; t++) begin
         bus.sense_5 = p5[t]; bus.sense_10 = p10[t]; bus.accept_en = pacc[t];
         @(posedge clk);
         @(negedge clk);
         o_coin[t] = bus.coin; o_rej[t] = bus.coin_reject;
         o_jam[t]  = bus.jam;  o_pend[t] = bus.pending;
      end
   endtask

   function automatic bit raw_at(input bit sel10, input int i);
      if (i < 1) return 1'b0;
      return sel10 ? p10[i] : p5[i];
   endfunction

   // Reference model: debounce as a sliding window, insertions as episodes, then the buffer table.
   task automatic compute_model();
      bit in_ep, any5, any10, all5, all10;
      int r;
      bit pend;
      bit [1:0] bufc, e;
      for (int t = 0; t <= MAXLEN + 2; t++) begin
         ev[t] = 2'b00; rev[t] = 1'b0; x_jam[t] = 1'b0;
         x_coin[t] = 2'b00; x_rej[t] = 1'b0; x_pend[t] = 1'b0;
      end
      ff5[0] = 1'b0; ff10[0] = 1'b0;
      for (int t = 1; t <= plen; t++) begin
         ff5[t] = ff5[t-1]; ff10[t] = ff10[t-1];
         all5 = 1'b1; all10 = 1'b1;
         for (int k = t - 2 - D; k <= t - 2; k++) begin
            if (raw_at(1'b0, k) != raw_at(1'b0, t - 2 - D)) all5 = 1'b0;
            if (raw_at(1'b1, k) != raw_at(1'b1, t - 2 - D)) all10 = 1'b0;
         end
         if (all5)  ff5[t]  = raw_at(1'b0, t - 2 - D);
         if (all10) ff10[t] = raw_at(1'b1, t - 2 - D);
      end
      in_ep = 1'b0; any5 = 1'b0; any10 = 1'b0; r = 0;
      for (int t = 0; t <= plen; t++) begin
         if (!in_ep) begin
            if (ff5[t] || ff10[t]) begin
               in_ep = 1'b1; r = t; any5 = ff5[t]; any10 = ff10[t];
               if (t >= r + M) x_jam[t+1] = 1'b1;
            end
         end else if (!ff5[t] && !ff10[t]) begin
            in_ep = 1'b0;
            if (t - r >= M) begin
               if (t - r == M) x_jam[t+1] = 1'b1;
            end else if (any5 && any10) begin
               rev[t+1] = 1'b1;
            end else begin
               ev[t+1] = any5 ? 2'b01 : 2'b10;
            end
         end else begin
            any5  = any5  | ff5[t];
            any10 = any10 | ff10[t];
            if (t >= r + M) x_jam[t+1] = 1'b1;
         end
      end
      pend = 1'b0; bufc = 2'b00;
      for (int t = 1; t <= plen; t++) begin
         e = ev[t];
         x_rej[t] = rev[t];
         if (pacc[t]) begin
            if (pend) begin
               x_coin[t] = bufc;
               if (e != 2'b00) bufc = e;
               else pend = 1'b0;
            end else begin
               x_coin[t] = e;
            end
         end else if (e != 2'b00) begin
            if (pend) x_rej[t] = 1'b1;
            else begin bufc = e; pend = 1'b1; end
         end
         x_pend[t] = pend;
      end
   endtask

   task automatic test_reset();
      clear_plan();
      reset = 1'b1;
      bus.sense_5 = 1'b1; bus.sense_10 = 1'b0; bus.accept_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.coin !== 2'b00) begin errors++; $display("FAIL reset_coin got %b want 00", bus.coin); end
      checks++; if (bus.coin_reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", bus.coin_reject); end
      checks++; if (bus.jam !== 1'b0) begin errors++; $display("FAIL reset_jam got %b want 0", bus.jam); end
      checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", bus.pending); end
      // Sensor already high across reset release counts as a fresh insertion.
      for (int t = 0; t < 15; t++) p5[t] = 1'b1;
      for (int t = 0; t <= 40; t++) pacc[t] = 1'b1;
      plen = 40;
      run_plan();
      compute_model();
      checks++; if (o_coin[22] !== 2'b01) begin errors++; $display("FAIL reset_held_coin cycle 22 got %b want 01", o_coin[22]); end
      for (int t = 1; t <= plen; t++) begin
         checks++;
         if ({o_coin[t], o_rej[t], o_jam[t], o_pend[t]} !== {x_coin[t], x_rej[t], x_jam[t], x_pend[t]}) begin
            errors++;
            $display("FAIL reset_held cycle %0d coin/rej/jam/pend got %b want %b", t,
                     {o_coin[t], o_rej[t], o_jam[t], o_pend[t]}, {x_coin[t], x_rej[t], x_jam[t], x_pend[t]});
         end
      end
   endtask

   task automatic test_bounce();
      int t0, w, b, ncoin;
      for (int it = 0; it < 3; it++) begin
         clear_plan();
         t0 = 2 + int'($urandom % 4);
         w  = (it == 0) ? 20 : 15 + int'($urandom % 11);
         add_pulse(1'b0, t0, 1); add_pulse(1'b0, t0 + 2, 1); add_pulse(1'b0, t0 + 4, 1);
         add_pulse(1'b0, t0 + 6, w);
         b = t0 + 6 + w;
         plen = b + 15;
         for (int t = 0; t <= plen; t++) pacc[t] = 1'b1;
         run_plan();
         compute_model();
         ncoin = 0;
         for (int t = 1; t <= plen; t++) if (o_coin[t] !== 2'b00) ncoin++;
         checks++; if (ncoin != 1) begin errors++; $display("FAIL bounce_count iter %0d got %0d coins want 1", it, ncoin); end
         checks++; if (o_coin[b + 7] !== 2'b01) begin errors++; $display("FAIL bounce_latency iter %0d got %b want 01 at cycle %0d", it, o_coin[b + 7], b + 7); end
         for (int t = 1; t <= plen; t++) begin
            checks++;
            if ({o_coin[t], o_rej[t], o_jam[t], o_pend[t]} !== {x_coin[t], x_rej[t], x_jam[t], x_pend[t]}) begin
               errors++;
               $display("FAIL bounce cycle %0d coin/rej/jam/pend got %b want %b", t,
                        {o_coin[t], o_rej[t], o_jam[t], o_pend[t]}, {x_coin[t], x_rej[t], x_jam[t], x_pend[t]});
            end
         end
      end
   endtask

   task automatic test_gated();
      clear_plan();
      add_pulse(1'b1, 2, 10);
      plen = 40;
      for (int t = 29; t <= plen; t++) pacc[t] = 1'b1;
      run_plan();
      compute_model();
      checks++; if (o_pend[25] !== 1'b1) begin errors++; $display("FAIL gated_pending got %b want 1", o_pend[25]); end
      checks++; if (o_coin[29] !== 2'b10) begin errors++; $display("FAIL gated_coin got %b want 10", o_coin[29]); end
      checks++; if (o_pend[30] !== 1'b0) begin errors++; $display("FAIL gated_pending_clear got %b want 0", o_pend[30]); end
      for (int t = 1; t <= plen; t++) begin
         checks++;
         if ({o_coin[t], o_rej[t], o_jam[t], o_pend[t]} !== {x_coin[t], x_rej[t], x_jam[t], x_pend[t]}) begin
            errors++;
            $display("FAIL gated cycle %0d coin/rej/jam/pend got %b want %b", t,
                     {o_coin[t], o_rej[t], o_jam[t], o_pend[t]}, {x_coin[t], x_rej[t], x_jam[t], x_pend[t]});
         end
      end
   endtask

   task automatic test_drop();
      int ncoin;
      clear_plan();
      add_pulse(1'b0, 2, 8);
      add_pulse(1'b1, 20, 8);
      plen = 55;
      for (int t = 45; t <= plen; t++) pacc[t] = 1'b1;
      run_plan();
      compute_model();
      ncoin = 0;
      for (int t = 1; t <= plen; t++) if (o_coin[t] !== 2'b00) ncoin++;
      checks++; if (o_pend[30] !== 1'b1) begin errors++; $display("FAIL drop_pending got %b want 1", o_pend[30]); end
      checks++; if (o_rej[35] !== 1'b1) begin errors++; $display("FAIL drop_reject got %b want 1", o_rej[35]); end
      checks++; if (o_coin[45] !== 2'b01) begin errors++; $display("FAIL drop_coin got %b want 01", o_coin[45]); end
      checks++; if (ncoin != 1) begin errors++; $display("FAIL drop_count got %0d want 1", ncoin); end
      for (int t = 1; t <= plen; t++) begin
         checks++;
         if ({o_coin[t], o_rej[t], o_jam[t], o_pend[t]} !== {x_coin[t], x_rej[t], x_jam[t], x_pend[t]}) begin
            errors++;
            $display("FAIL drop cycle %0d coin/rej/jam/pend got %b want %b", t,
                     {o_coin[t], o_rej[t], o_jam[t], o_pend[t]}, {x_coin[t], x_rej[t], x_jam[t], x_pend[t]});
         end
      end
   endtask

   task automatic test_both();
      int ncoin, nrej;
      clear_plan();
      add_pulse(1'b0, 2, 10);
      add_pulse(1'b1, 2, 10);
      plen = 30;
      for (int t = 0; t <= plen; t++) pacc[t] = 1'b1;
      run_plan();
      compute_model();
      ncoin = 0; nrej = 0;
      for (int t = 1; t <= plen; t++) begin
         if (o_coin[t] !== 2'b00) ncoin++;
         if (o_rej[t] !== 1'b0) nrej++;
      end
      checks++; if (o_rej[19] !== 1'b1) begin errors++; $display("FAIL both_reject got %b want 1", o_rej[19]); end
      checks++; if (ncoin != 0) begin errors++; $display("FAIL both_coins got %0d want 0", ncoin); end
      checks++; if (nrej != 1) begin errors++; $display("FAIL both_reject_count got %0d want 1", nrej); end
      for (int t = 1; t <= plen; t++) begin
         checks++;
         if ({o_coin[t], o_rej[t], o_jam[t], o_pend[t]} !== {x_coin[t], x_rej[t], x_jam[t], x_pend[t]}) begin
            errors++;
            $display("FAIL both cycle %0d coin/rej/jam/pend got %b want %b", t,
                     {o_coin[t], o_rej[t], o_jam[t], o_pend[t]}, {x_coin[t], x_rej[t], x_jam[t], x_pend[t]});
         end
      end
   endtask

   task automatic test_jam();
      int ncoin;
      clear_plan();
      add_pulse(1'b1, 2, 80);
      add_pulse(1'b0, 100, 49);
      add_pulse(1'b0, 170, 50);
      plen = 240;
      for (int t = 0; t <= plen; t++) pacc[t] = 1'b1;
      run_plan();
      compute_model();
      ncoin = 0;
      for (int t = 1; t <= plen; t++) if (o_coin[t] !== 2'b00) ncoin++;
      checks++; if (o_jam[58] !== 1'b0) begin errors++; $display("FAIL jam_early got %b want 0", o_jam[58]); end
      checks++; if (o_jam[59] !== 1'b1) begin errors++; $display("FAIL jam_set got %b want 1", o_jam[59]); end
      checks++; if (o_jam[88] !== 1'b1) begin errors++; $display("FAIL jam_hold got %b want 1", o_jam[88]); end
      checks++; if (o_jam[89] !== 1'b0) begin errors++; $display("FAIL jam_clear got %b want 0", o_jam[89]); end
      checks++; if (o_coin[156] !== 2'b01) begin errors++; $display("FAIL jam_w49_coin got %b want 01", o_coin[156]); end
      checks++; if (o_jam[227] !== 1'b1) begin errors++; $display("FAIL jam_w50 got %b want 1", o_jam[227]); end
      checks++; if (o_jam[228] !== 1'b0) begin errors++; $display("FAIL jam_w50_clear got %b want 0", o_jam[228]); end
      checks++; if (ncoin != 1) begin errors++; $display("FAIL jam_coins got %0d want 1", ncoin); end
      for (int t = 1; t <= plen; t++) begin
         checks++;
         if ({o_coin[t], o_rej[t], o_jam[t], o_pend[t]} !== {x_coin[t], x_rej[t], x_jam[t], x_pend[t]}) begin
            errors++;
            $display("FAIL jam cycle %0d coin/rej/jam/pend got %b want %b", t,
                     {o_coin[t], o_rej[t], o_jam[t], o_pend[t]}, {x_coin[t], x_rej[t], x_jam[t], x_pend[t]});
         end
      end
   endtask

   task automatic test_random_stream();
      int t, kind, w5, w10, s10, fin;
      for (int it = 0; it < 2; it++) begin
         clear_plan();
         t = 2;
         while (t < MAXLEN - 90) begin
            kind = int'($urandom % 10);
            if (kind == 0) begin
               w5 = 6 + int'($urandom % 20); w10 = 6 + int'($urandom % 20);
               s10 = t + int'($urandom % 3);
               add_pulse(1'b0, t, w5); add_pulse(1'b1, s10, w10);
               fin = (t + w5 > s10 + w10) ? t + w5 : s10 + w10;
            end else if (kind == 1) begin
               add_pulse(1'b1, t, 55);
               fin = t + 55;
            end else begin
               w5 = 6 + int'($urandom % 25);
               add_pulse(kind[0], t, w5);
               fin = t + w5;
            end
            t = fin + 8 + int'($urandom % 8);
         end
         plen = t + 15;
         for (int k = 0; k <= plen; k++) pacc[k] = bit'($urandom % 2);
         run_plan();
         compute_model();
         for (int k = 1; k <= plen; k++) begin
            checks++;
            if ({o_coin[k], o_rej[k], o_jam[k], o_pend[k]} !== {x_coin[k], x_rej[k], x_jam[k], x_pend[k]}) begin
               errors++;
               $display("FAIL random iter %0d cycle %0d coin/rej/jam/pend got %b want %b", it, k,
                        {o_coin[k], o_rej[k], o_jam[k], o_pend[k]}, {x_coin[k], x_rej[k], x_jam[k], x_pend[k]});
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      int ncoin, nrej, waited;
      clear_plan();
      run_plan();
      @(negedge clk);
      bus.sense_10 = 1'b1; bus.accept_en = 1'b1;
      repeat (12) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.coin, bus.coin_reject, bus.jam, bus.pending} !== 5'b0) begin
         errors++; $display("FAIL midact10_outputs got %b want 00000", {bus.coin, bus.coin_reject, bus.jam, bus.pending});
      end
      bus.sense_10 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ncoin = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.coin !== 2'b00) ncoin++;
      end
      checks++; if (ncoin != 0) begin errors++; $display("FAIL midact10_no_coin got %0d coins want 0", ncoin); end
      // Buffered coin discarded by reset.
      bus.accept_en = 1'b0; bus.sense_5 = 1'b1;
      repeat (8) @(negedge clk);
      bus.sense_5 = 1'b0;
      waited = 0;
      while (bus.pending !== 1'b1 && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL pend_before_reset got %b want 1", bus.pending); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.coin, bus.coin_reject, bus.jam, bus.pending} !== 5'b0) begin
         errors++; $display("FAIL pend_reset_outputs got %b want 00000", {bus.coin, bus.coin_reject, bus.jam, bus.pending});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus.accept_en = 1'b1;
      ncoin = 0; nrej = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.coin !== 2'b00) ncoin++;
         if (bus.coin_reject !== 1'b0) nrej++;
      end
      checks++; if (ncoin != 0) begin errors++; $display("FAIL pend_reset_no_coin got %0d coins want 0", ncoin); end
      checks++; if (nrej != 0) begin errors++; $display("FAIL pend_reset_no_reject got %0d rejects want 0", nrej); end
   endtask

   initial begin
      bus.sense_5 = 1'b0; bus.sense_10 = 1'b0; bus.accept_en = 1'b0;
      test_reset();
      test_bounce();
      test_gated();
      test_drop();
      test_both();
      test_jam();
      test_random_stream();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
